serial_subtractor: RTL and testbench

Bit-serial, multi-cycle subtractor that computes a - b one bit per clock, LSB first. It reuses the full-adder carry chain in two's-complement form: a + ~b + 1. The block is the inverse-operation counterpart to the team's ripple-carry adder. It sits between a valid/ready producer and a valid/ready consumer, and trades area for latency in small datapaths.

---
 rtl/serial_subtractor.sv | 105 ++++++++++
 tb/tb_serial_subtractor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b via a + ~b + 1, LSB first, valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d, full;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic ai, nbi, di, co, last;
  always_comb begin
    ai = a_q[0];
    nbi = ~b_q[0];
    di = ai ^ nbi ^ c_q;
    co = (ai & nbi) | (c_q & (ai ^ nbi));
    full = {di, res_q[WIDTH-1:1]};
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    cnt_d = cnt_q;
    c_d = c_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d = diff_q;
    borrow_d = borrow_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      a_d = a;
      b_d = b;
      c_d = 1'b1;
      cnt_d = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      res_d = full;
      c_d = co;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        diff_d = full;
        borrow_d = ~co;
        ovf_d = (a_msb_q != b_msb_q) && (full[WIDTH-1] != a_msb_q);
        zero_d = full == '0;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      c_q <= 1'b1;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q <= '0;
      borrow_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      c_q <= c_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q <= diff_d;
      borrow_q <= borrow_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign in_ready = (state_q == IDLE) && !rst;
  assign out_valid = state_q == DONE;
  assign diff = diff_q;
  assign borrow = borrow_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor against an integer a-b model.
module tb_serial_subtractor;
  localparam int W = 4;
  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    logic         z;
  } exp_t;
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, borrow, ovf, zero;
  logic [W-1:0] a, b, diff;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, last_done = 0;
  int acc[4];
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow),
    .ovf(ovf), .zero(zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int sx, sy, sd;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    sd = sx - sy;
    e.d = W'(int'(x) - int'(y));
    e.br = x < y;
    e.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    e.z = e.d == 0;
    return e;
  endfunction
  always @(negedge clk) begin
    if (in_valid && in_ready) q.push_back(model(a, b));
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", diff, e.d);
        chk("borrow", borrow, e.br);
        chk("ovf", ovf, e.ov);
        chk("zero", zero, e.z);
      end
      last_done = cyc + 1;
    end
  end
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    int lat = 0;
    exp_t e;
    @(posedge clk);
    #1;
    a = x;
    b = y;
    in_valid = 1;
    out_ready = 0;
    wait_ready();
    e = model(x, y);
    @(posedge clk);
    #1;
    in_valid = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency", lat, W);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      chk("hold_diff", diff, e.d);
      chk("hold_borrow", borrow, e.br);
      chk("hold_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("drop_valid", out_valid, 0);
    chk("rise_ready", in_ready, 1);
  endtask
  initial begin
    logic seen;
    logic [W-1:0] va[4], vb[4];
    rst = 1;
    in_valid = 0;
    out_ready = 0;
    a = 0;
    b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {diff, borrow, ovf, zero}, 0);
    rst = 0;
    #1;
    chk("idle_ready", in_ready, 1);
    op(8, 4, 0);
    op(3, 5, 0);
    op(7, 8, 0);
    op(0, 0, 0);
    op(9, 0, 0);
    op(3, 5, 5);
    @(posedge clk);
    #1;
    a = 5;
    b = 3;
    in_valid = 1;
    wait_ready();
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_outs", {diff, borrow, ovf, zero}, 0);
    rst = 0;
    q.delete();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      seen |= out_valid;
      @(posedge clk);
      #1;
    end
    chk("no_pulse", seen, 0);
    chk("post_rst_ready", in_ready, 1);
    op(12, 8, 0);
    va = '{4'd10, 4'd2, 4'd15, 4'd6};
    vb = '{4'd3, 4'd9, 4'd1, 4'd6};
    @(posedge clk);
    #1;
    out_ready = 1;
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      a = va[k];
      b = vb[k];
      wait_ready();
      @(posedge clk);
      #1;
      acc[k] = cyc;
      if (k > 0) chk("b2b_interval", acc[k] - acc[k-1], W + 2);
    end
    in_valid = 0;
    for (int n = 0; n < 100 && q.size() > 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_drain", q.size(), 0);
    chk("b2b_total", last_done - acc[0], 4 * (W + 2) - 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
